// File: rtl/text_overlay_pkg.sv
// Shared constants and types for the character-buffer text overlay.
// Holds default screen geometry, control-code values and the controller state type.
package text_overlay_pkg;

    localparam int COLS_DEF = 64;
    localparam int ROWS_DEF = 32;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    function automatic logic is_print(input logic [7:0] b);
        return (b >= CH_SPACE) && (b <= CH_TILDE);
    endfunction

endpackage

// File: rtl/text_overlay_if.sv
// Host byte stream plus font-engine display signals for text_overlay.
// master = host/video source side, slave = the overlay itself.
interface text_overlay_if #(
    parameter int COLS = 64,
    parameter int ROWS = 32
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic           blank;
    logic           vsync;
    logic [7:0]     char_x;
    logic [7:0]     char_y;
    logic [255:0]   ascii_char;
    logic           wr_valid;
    logic [7:0]     wr_data;
    logic           wr_ready;
    logic           pix_on;
    logic           blank_out;
    logic [CW-1:0]  cursor_col;
    logic [RW-1:0]  cursor_row;

    modport master (
        output blank, vsync, char_x, char_y, ascii_char, wr_valid, wr_data,
        input  wr_ready, pix_on, blank_out, cursor_col, cursor_row
    );

    modport slave (
        input  blank, vsync, char_x, char_y, ascii_char, wr_valid, wr_data,
        output wr_ready, pix_on, blank_out, cursor_col, cursor_row
    );

endinterface

// File: rtl/text_ram.sv
// Simple dual-port character RAM: one write port, one registered read port.
// A read of the address being written returns the previous contents.
module text_ram #(
    parameter int DEPTH = 2048,
    parameter int DW    = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/text_overlay.sv
// Text overlay: host-written COLS x ROWS ASCII screen, looked up per font-engine cell.
// Define TEXT_CURSOR_EN to add a blinking inverted cursor driven by a vsync frame counter.
module text_overlay
    import text_overlay_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic           clk,
    input  logic           reset,
    text_overlay_if.slave  bus
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int AW    = CW + RW;
    localparam int DEPTH = COLS * ROWS;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] COL_MAX   = CW'(COLS - 1);
    localparam logic [7:0]    COLS_B    = 8'(COLS);
    localparam logic [7:0]    ROWS_B    = 8'(ROWS);

    state_e         r_state;
    logic [AW-1:0]  r_clr_addr;
    logic [CW-1:0]  r_col;
    logic [RW-1:0]  r_row;

    logic           w_accept;
    logic           w_we;
    logic [AW-1:0]  w_waddr;
    logic [7:0]     w_wdata;
    logic [AW-1:0]  w_raddr;
    logic [7:0]     w_code;
    logic           w_oow;
    logic           w_inv;

    logic           r_oow_d;
    logic           r_blank_d;
    logic           r_pix;
    logic           r_blank_out;

    assign bus.wr_ready = (r_state == ST_IDLE);
    assign w_accept     = bus.wr_valid && bus.wr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
            r_col      <= '0;
            r_row      <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == LAST_ADDR) begin
                        r_state <= ST_IDLE;
                        r_col   <= '0;
                        r_row   <= '0;
                    end
                end
                ST_IDLE: begin
                    if (w_accept) begin
                        if (is_print(bus.wr_data)) begin
                            if (r_col == COL_MAX) begin
                                r_col <= '0;
                                r_row <= r_row + 1'b1;
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
                        end else begin
                            case (bus.wr_data)
                                CH_LF: begin
                                    r_col <= '0;
                                    r_row <= r_row + 1'b1;
                                end
                                CH_CR: r_col <= '0;
                                CH_BS: if (r_col != '0) r_col <= r_col - 1'b1;
                                CH_FF: begin
                                    r_state    <= ST_CLEAR;
                                    r_clr_addr <= '0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    // The clear engine owns the write port for its whole duration.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = {r_row, r_col};
        w_wdata = bus.wr_data;
        if (r_state == ST_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_addr;
            w_wdata = CH_SPACE;
        end else if (w_accept && is_print(bus.wr_data)) begin
            w_we = 1'b1;
        end
    end

    assign w_raddr = {bus.char_y[RW-1:0], bus.char_x[CW-1:0]};
    assign w_oow   = (bus.char_x >= COLS_B) || (bus.char_y >= ROWS_B);

    text_ram #(
        .DEPTH (DEPTH),
        .DW    (8)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_code)
    );

`ifdef TEXT_CURSOR_EN
    logic       r_vsync_d;
    logic [5:0] r_frame_cnt;
    logic       r_cur_hit;

    // Cursor hit is evaluated with the read address so it lines up with the RAM code.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vsync_d   <= 1'b0;
            r_frame_cnt <= '0;
            r_cur_hit   <= 1'b0;
        end else begin
            r_vsync_d <= bus.vsync;
            if (bus.vsync && !r_vsync_d)
                r_frame_cnt <= r_frame_cnt + 1'b1;
            r_cur_hit <= (r_state == ST_IDLE) && !w_oow &&
                         (bus.char_x[CW-1:0] == r_col) &&
                         (bus.char_y[RW-1:0] == r_row);
        end
    end

    assign w_inv = r_cur_hit && r_frame_cnt[5];
`else
    assign w_inv = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_oow_d     <= 1'b1;
            r_blank_d   <= 1'b1;
            r_pix       <= 1'b0;
            r_blank_out <= 1'b1;
        end else begin
            r_oow_d     <= w_oow;
            r_blank_d   <= bus.blank;
            r_pix       <= (bus.ascii_char[w_code] ^ w_inv) && !r_oow_d && !r_blank_d;
            r_blank_out <= r_blank_d;
        end
    end

    assign bus.pix_on     = r_pix;
    assign bus.blank_out  = r_blank_out;
    assign bus.cursor_col = r_col;
    assign bus.cursor_row = r_row;

endmodule
